mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-access controller for the 3-stage pipeline. Accepts one load or store at a time from the execute stage, runs a request/acknowledge handshake with the data cache, and drives the memory data register: its CPU-side word, its cache-side word, and its load/store select. Loads return aligned, extended data. The pipeline is stalled while an access is outstanding.

## Interface
- AW, 32, address width
- DW, 32, data width (fixed at 32; byte enables are DW/8)
- TIMEOUT, 16, cycles to wait for cache_ack before error (macro-gated)

- clk  in  1  system clock, all logic rising-edge
- clr  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a memory op
- ex_is_store  in  1  1 = store, 0 = load
- ex_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as word)
- ex_signed  in  1  load sign-extends when 1
- ex_addr  in  AW  byte address
- ex_wdata  in  DW  store data, right-justified
- ex_ready  out  1  op accepted this cycle when ex_valid & ex_ready
- stall  out  1  = ~ex_ready
- cache_req, cache_we  out  1  request, write strobe
- cache_addr  out  AW  word-aligned address ({ex_addr[AW-1:2],2'b00})
- cache_be  out  DW/8  byte enables
- cache_wdata  out  DW  store data replicated into lanes
- cache_ack  in  1  cache completes request this cycle
- cache_rdata  in  DW  valid when cache_ack
- ld_str  out  1  MDR select: 1 = cpu word, 0 = cache word
- mdr_cpu_data  out  DW  lane-replicated store word
- mdr_cache_data  out  DW  extended load word, held until next load completes
- done  out  1  one-cycle completion pulse
- done_is_load  out  1  qualifies done
- misalign  out  1  one-cycle pulse with done on misaligned op
- err  out  1  sticky timeout flag (macro-gated; else tied 0)

## Operation
- States: IDLE, REQ, DONE.
- IDLE: ex_ready=1. On ex_valid, latch op fields. If aligned → REQ; if misaligned (half & addr[0], word & addr[1:0]≠0) → DONE with misalign set and no cache request.
- REQ: cache_req=1, fields stable. On cache_ack → DONE; load data captured from cache_rdata that cycle.
- DONE: done=1 for one cycle, then → IDLE. ex_ready=0.
- Store: cache_we=1. Byte lanes: byte be=1<<addr[1:0], wdata={4{b}}; half be=addr[1]?1100:0011, wdata={2{h}}; word be=1111.
- Load: select lane by addr[1:0]/addr[1], then zero- or sign-extend to 32 bits into mdr_cache_data.
- ld_str = latched ex_is_store. It changes only on acceptance and holds through DONE.
- A misaligned load leaves mdr_cache_data unchanged.

## Timing
- Reset (clr high at an edge): state IDLE; every output 0 except ex_ready=1. mdr_* are 0, err is 0.
- Accept at edge N. cache_req is high from N+1. For an ack seen at edge M, done pulses in the cycle after M and ex_ready returns the cycle after that.
- Minimum accepted-to-accepted spacing: 3 cycles (ack in first REQ cycle).
- Misaligned op: done+misalign in cycle N+1.
- A cache_ack outside REQ is ignored.
- clr mid-REQ: abandon the access, drop cache_req next cycle, no done.

## Configuration
- MAC_TIMEOUT_EN defined: a counter runs in REQ. When it reaches TIMEOUT cycles with no ack: drop cache_req, set err (sticky until clr), pulse done, and leave mdr_cache_data unchanged.
- Undefined: REQ waits forever and err is constant 0.

## Structure
- Shared package mac_pkg: size encodings (SZ_BYTE/HALF/WORD), state encoding, and the lane-select/extend function.
- Sub-module mac_lane_align: combinational load extraction/extension plus store replication/byte enables. It is instantiated once.
- The FSM and the timeout counter stay in the top module.

## Test plan
- Word store 0xDEADBEEF at 0x100, ack after 2 cycles → cache_be=1111, cache_addr=0x100, ld_str=1, done 1 cycle after ack.
- Byte load signed at 0x103, rdata=0x80112233 → mdr_cache_data=0xFFFFFF80. The same load unsigned → 0x00000080.
- Half store 0xABCD at 0x202 → be=1100, wdata=0xABCDABCD.
- Word load at 0x101 → no cache_req, done+misalign in cycle N+1, mdr_cache_data unchanged.
- clr asserted in the second REQ cycle → cache_req low next cycle, no done, ex_ready=1.
- MAC_TIMEOUT_EN with TIMEOUT=16 and ack never asserted → err rises and done pulses after 16 REQ cycles. err stays high until clr.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared encodings and load lane helpers for mem_access_ctrl.
package mac_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mac_state_e;

    // Size 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] a,
                                                input logic sgn, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/mac_lane_align.sv
// mac_lane_align: store lane replication / byte enables and load lane extraction.
module mac_lane_align
    import mac_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    // Lane steering for both directions of the access.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
            end
        endcase
        rdata_ext = load_extend(size, addr_lo, is_signed, rdata);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store controller between execute stage,
// data cache and the memory data register.
// Optional: define MAC_TIMEOUT_EN to abort a request after TIMEOUT cycles
// without cache_ack and raise the sticky err flag.
module mem_access_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
`ifdef MAC_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            ex_valid,
    input  logic            ex_is_store,
    input  logic [1:0]      ex_size,
    input  logic            ex_signed,
    input  logic [AW-1:0]   ex_addr,
    input  logic [DW-1:0]   ex_wdata,
    output logic            ex_ready,
    output logic            stall,
    output logic            cache_req,
    output logic            cache_we,
    output logic [AW-1:0]   cache_addr,
    output logic [DW/8-1:0] cache_be,
    output logic [DW-1:0]   cache_wdata,
    input  logic            cache_ack,
    input  logic [DW-1:0]   cache_rdata,
    output logic            ld_str,
    output logic [DW-1:0]   mdr_cpu_data,
    output logic [DW-1:0]   mdr_cache_data,
    output logic            done,
    output logic            done_is_load,
    output logic            misalign,
    output logic            err
);

    mac_state_e      state, state_nxt;
    logic            op_store, op_signed, op_mis;
    logic [1:0]      op_size;
    logic [AW-1:0]   op_addr;
    logic [DW-1:0]   op_wdata;
    logic [DW-1:0]   mdr_q;
    logic [DW/8-1:0] lane_be;
    logic [DW-1:0]   lane_wdata, lane_rdata;
    logic            timeout_hit;

    mac_lane_align u_lane (
        .size      (op_size),
        .addr_lo   (op_addr[1:0]),
        .is_signed (op_signed),
        .wdata     (op_wdata),
        .rdata     (cache_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

`ifdef MAC_TIMEOUT_EN
    localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (state == ST_REQ) && !cache_ack && (to_cnt == TO_LAST);
    assign err         = err_q;

    // Count REQ cycles; sticky err on expiry, cleared only by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == ST_REQ) ? to_cnt + 1'b1 : '0;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (clr)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: misaligned ops skip the cache and complete immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ex_valid)
                         state_nxt = is_misaligned(ex_size, ex_addr[1:0]) ? ST_DONE : ST_REQ;
            ST_REQ:  if (cache_ack || timeout_hit)
                         state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Op latch on acceptance and load-data capture on ack.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_store  <= 1'b0;
            op_signed <= 1'b0;
            op_mis    <= 1'b0;
            op_size   <= '0;
            op_addr   <= '0;
            op_wdata  <= '0;
            mdr_q     <= '0;
        end else begin
            if (state == ST_IDLE && ex_valid) begin
                op_store  <= ex_is_store;
                op_signed <= ex_signed;
                op_mis    <= is_misaligned(ex_size, ex_addr[1:0]);
                op_size   <= ex_size;
                op_addr   <= ex_addr;
                op_wdata  <= ex_wdata;
            end
            if (state == ST_REQ && cache_ack && !op_store)
                mdr_q <= lane_rdata;
        end
    end

    // Outputs decoded from state and latched op.
    always_comb begin
        ex_ready       = (state == ST_IDLE);
        stall          = !ex_ready;
        cache_req      = (state == ST_REQ);
        cache_we       = cache_req & op_store;
        cache_be       = cache_req ? lane_be : '0;
        cache_addr     = {op_addr[AW-1:2], 2'b00};
        cache_wdata    = lane_wdata;
        mdr_cpu_data   = lane_wdata;
        mdr_cache_data = mdr_q;
        ld_str         = op_store;
        done           = (state == ST_DONE);
        done_is_load   = done & !op_store;
        misalign       = done & op_mis;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr, ex_valid, ex_is_store, ex_signed;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic        ex_ready, stall, cache_req, cache_we, cache_ack;
    logic [31:0] cache_addr, cache_wdata, cache_rdata;
    logic [3:0]  cache_be;
    logic        ld_str, done, done_is_load, misalign, err;
    logic [31:0] mdr_cpu_data, mdr_cache_data;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic        is_load;
        logic        mis;
        logic [31:0] mdr;
        logic        ld_str;
        logic [31:0] cpu;
        logic        err;
    } done_exp_t;

    req_exp_t  req_q[$];
    done_exp_t done_q[$];
    req_exp_t  mr;
    done_exp_t md;
    int        total = 0;
    int        bad   = 0;
    logic [31:0] model_mdr = '0;
    logic        model_err = 1'b0;
    bit          req_seen  = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .AW(32),
        .DW(32)
`ifdef MAC_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .clr(clr), .ex_valid(ex_valid), .ex_is_store(ex_is_store),
        .ex_size(ex_size), .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_ready(ex_ready), .stall(stall), .cache_req(cache_req), .cache_we(cache_we),
        .cache_addr(cache_addr), .cache_be(cache_be), .cache_wdata(cache_wdata),
        .cache_ack(cache_ack), .cache_rdata(cache_rdata), .ld_str(ld_str),
        .mdr_cpu_data(mdr_cpu_data), .mdr_cache_data(mdr_cache_data), .done(done),
        .done_is_load(done_is_load), .misalign(misalign), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: arithmetic view of sizes, lanes and extension.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] addr,
                                             input bit sgn, input logic [31:0] rd);
        int          nb   = nbytes(sz);
        logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
        logic [31:0] v    = (rd >> (8 * (addr % 4))) & mask;
        if (sgn && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1)
            v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] addr);
        int nb = nbytes(sz);
        return 4'(((1 << nb) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
        int nb = nbytes(sz);
        if (nb == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // Monitor: pop expectations whenever the DUT presents a request or completion.
    always @(negedge clk) begin
        check("stall_inv", stall, !ex_ready);
        if (cache_req && !req_seen) begin
            req_seen = 1'b1;
            if (req_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_req: got addr %h want no request", cache_addr);
            end else begin
                mr = req_q.pop_front();
                check("req_addr",  cache_addr,  mr.addr);
                check("req_be",    cache_be,    mr.be);
                check("req_we",    cache_we,    mr.we);
                check("req_wdata", cache_wdata, mr.wdata);
            end
        end
        if (!cache_req) req_seen = 1'b0;
        if (done) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 want 0");
            end else begin
                md = done_q.pop_front();
                check("done_is_load", done_is_load,   md.is_load);
                check("misalign",     misalign,       md.mis);
                check("mdr_cache",    mdr_cache_data, md.mdr);
                check("ld_str",       ld_str,         md.ld_str);
                check("mdr_cpu",      mdr_cpu_data,   md.cpu);
                check("err",          err,            md.err);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", ex_ready, 1);
    endtask

    // Issue one op; records expectations, then acts as the cache. Called at negedge.
    task automatic do_op(input bit st, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly);
        bit        mis = (addr % nbytes(sz)) != 0;
        req_exp_t  r;
        done_exp_t d;
        wait_ready();
        if (!mis) begin
            r.addr = addr & 32'hFFFF_FFFC; r.be = ref_be(sz, addr);
            r.we = st; r.wdata = ref_wdata(sz, wd);
            req_q.push_back(r);
            if (!st) model_mdr = ref_load(sz, addr, sg, rd);
        end
        d.is_load = !st; d.mis = mis; d.mdr = model_mdr; d.ld_str = st;
        d.cpu = ref_wdata(sz, wd); d.err = model_err;
        done_q.push_back(d);
        ex_valid = 1'b1; ex_is_store = st; ex_size = sz; ex_signed = sg;
        ex_addr = addr; ex_wdata = wd;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
        if (mis) begin
            check("mis_done",   done,      1);
            check("mis_flag",   misalign,  1);
            check("mis_no_req", cache_req, 0);
        end else begin
            repeat (dly) @(posedge clk);
            @(negedge clk);
            cache_ack = 1'b1; cache_rdata = rd;
            @(posedge clk); #1;
            cache_ack = 1'b0; cache_rdata = $urandom;
            check("done_after_ack", done, 1);
        end
        @(negedge clk);
        @(negedge clk);
        check("ready_back", ex_ready, 1);
    endtask

    task automatic stray_ack();
        @(negedge clk);
        cache_ack = 1'b1; cache_rdata = $urandom;
        @(posedge clk); #1;
        cache_ack = 1'b0;
        check("stray_no_done", done, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        model_mdr = '0;
        model_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; ex_valid = 1'b0; ex_is_store = 1'b0; ex_size = '0; ex_signed = 1'b0;
        ex_addr = '0; ex_wdata = '0; cache_ack = 1'b0; cache_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ex_ready, 1);
        check("rst_req",   cache_req, 0);
        check("rst_we",    cache_we, 0);
        check("rst_addr",  cache_addr, 0);
        check("rst_be",    cache_be, 0);
        check("rst_wdata", cache_wdata, 0);
        check("rst_ldstr", ld_str, 0);
        check("rst_cpu",   mdr_cpu_data, 0);
        check("rst_cache", mdr_cache_data, 0);
        check("rst_done",  done, 0);
        check("rst_dil",   done_is_load, 0);
        check("rst_mis",   misalign, 0);
        check("rst_err",   err, 0);
        clr = 1'b0;
        @(negedge clk);

        do_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 2);
        do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8011_2233, 0);
        check("byte_signed",   mdr_cache_data, 32'hFFFF_FF80);
        do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8011_2233, 1);
        check("byte_unsigned", mdr_cache_data, 32'h0000_0080);
        do_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 0);
        do_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 0);
        check("mis_keeps_mdr", mdr_cache_data, 32'h0000_0080);
        stray_ack();
        check("stray_keeps_mdr", mdr_cache_data, 32'h0000_0080);

        // Abort: clr in the second REQ cycle.
        wait_ready();
        mr.addr = 32'h300; mr.be = 4'hF; mr.we = 1'b0; mr.wdata = 32'h5555_5555;
        req_q.push_back(mr);
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_size = 2'b10; ex_addr = 32'h300; ex_wdata = 32'h5555_5555;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        check("abort_req",   cache_req, 0);
        check("abort_done",  done, 0);
        check("abort_ready", ex_ready, 1);
        clr = 1'b0;
        model_mdr = '0;
        repeat (3) @(negedge clk);

`ifdef MAC_TIMEOUT_EN
        begin
            int n = 0;
            mr.addr = 32'h400; mr.be = 4'hF; mr.we = 1'b0; mr.wdata = 32'h0;
            req_q.push_back(mr);
            model_err = 1'b1;
            md.is_load = 1'b1; md.mis = 1'b0; md.mdr = model_mdr; md.ld_str = 1'b0;
            md.cpu = 32'h0; md.err = 1'b1;
            done_q.push_back(md);
            ex_valid = 1'b1; ex_is_store = 1'b0; ex_size = 2'b10; ex_addr = 32'h400; ex_wdata = 32'h0;
            @(posedge clk); #1;
            ex_valid = 1'b0;
            while (cache_req && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("timeout_cycles", n, 16);
            check("timeout_done",   done, 1);
            check("timeout_err",    err, 1);
            repeat (5) @(negedge clk);
            check("err_sticky", err, 1);
            do_reset();
            check("err_cleared", err, 0);
        end
`endif

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a = $urandom;
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a & ~((nbytes(sz) == 1) ? 32'h0 : 32'(nbytes(sz) - 1));
            if ($urandom_range(0, 7) == 0) stray_ack();
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  $urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        check("req_q_empty",  req_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
